multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the SCU CPU datapath. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/multicycle_ctrl_pkg.sv | 59 +++++
 rtl/multicycle_ctrl_decode.sv | 39 +++
 rtl/multicycle_ctrl.sv | 141 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared opcode, state and control-code definitions for the SCU multi-cycle controller.
// Optional macro ILLEGAL_TRAP_EN adds the HALT state used for unlisted opcodes.
package multicycle_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_RS  = 2'b01;
  localparam logic [1:0] PC_MEM = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_SVPC = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_NEG   = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
`ifdef ILLEGAL_TRAP_EN
    , ST_HALT = 3'd5
`endif
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP, CL_JMP, CL_BRZ, CL_BRN, CL_ALU, CL_SVPC, CL_ST, CL_LD, CL_JM, CL_ILL
  } op_class_t;

  typedef struct packed {
    op_class_t  cls;
    logic [1:0] alu_op;
    logic       alu_b_sel;
    logic [1:0] wb_sel;
    logic       sets_flags;
  } ctrl_word_t;

  // Classes that leave DECODE for a data-memory access instead of EXEC.
  function automatic logic is_mem_class(input op_class_t cls);
    return (cls == CL_ST) || (cls == CL_LD) || (cls == CL_JM);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode -> control-word decode used by the multi-cycle controller.
// Under ILLEGAL_TRAP_EN unlisted opcodes decode to CL_ILL, otherwise to CL_NOP.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  output ctrl_word_t     cw
);

  always_comb begin
    cw.cls        = CL_NOP;
    cw.alu_op     = ALU_ADD;
    cw.alu_b_sel  = 1'b0;
    cw.wb_sel     = WB_ALU;
    cw.sets_flags = 1'b0;
    case (opcode)
      OP_NOP:  cw.cls = CL_NOP;
      OP_ST:   cw.cls = CL_ST;
      OP_ADD:  begin cw.cls = CL_ALU; cw.sets_flags = 1'b1; end
      OP_INC:  begin cw.cls = CL_ALU; cw.sets_flags = 1'b1; cw.alu_b_sel = 1'b1; end
      OP_NEG:  begin cw.cls = CL_ALU; cw.sets_flags = 1'b1; cw.alu_op = ALU_NEG; end
      OP_SUB:  begin cw.cls = CL_ALU; cw.sets_flags = 1'b1; cw.alu_op = ALU_SUB; end
      OP_J:    cw.cls = CL_JMP;
      OP_BRZ:  cw.cls = CL_BRZ;
      OP_JM:   cw.cls = CL_JM;
      OP_BRN:  cw.cls = CL_BRN;
      OP_LD:   begin cw.cls = CL_LD; cw.wb_sel = WB_MEM; end
      OP_SVPC: begin cw.cls = CL_SVPC; cw.wb_sel = WB_SVPC; end
`ifdef ILLEGAL_TRAP_EN
      default: cw.cls = CL_ILL;
`else
      default: cw.cls = CL_NOP;
`endif
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the SCU CPU datapath.
// Optional macro ILLEGAL_TRAP_EN: unlisted opcodes trap into a sticky HALT state.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int         OPW      = 4,
  parameter logic [1:0] FLAG_RST = 2'b00
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           alu_z,
  input  logic           alu_n,
  input  logic           mem_rdy,
  output logic           mem_req,
  output logic           mem_we,
  output logic           ir_we,
  output logic           pc_we,
  output logic [1:0]     pc_sel,
  output logic           reg_we,
  output logic [1:0]     wb_sel,
  output logic [1:0]     alu_op,
  output logic           alu_b_sel,
  output logic [2:0]     state_o,
  output logic           illegal
);

  state_t     r_state, w_state_next;
  logic [1:0] r_flags, w_flags_next;   // {Z, N}
  ctrl_word_t w_cw;

  logic       w_mem_req, w_mem_we, w_ir_we, w_pc_we, w_reg_we, w_alu_b_sel;
  logic [1:0] w_pc_sel, w_wb_sel, w_alu_op;

  multicycle_ctrl_decode #(.OPW(OPW)) u_decode (
    .opcode (opcode),
    .cw     (w_cw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_flags <= FLAG_RST;
    end else begin
      r_state <= w_state_next;
      r_flags <= w_flags_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_flags_next = r_flags;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_sel     = PC_INC;
    w_reg_we     = 1'b0;
    w_wb_sel     = WB_ALU;
    w_alu_op     = ALU_ADD;
    w_alu_b_sel  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_rdy) begin
          w_ir_we      = 1'b1;
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (w_cw.cls)
          CL_JMP: begin
            w_pc_we = 1'b1; w_pc_sel = PC_RS; w_state_next = ST_FETCH;
          end
          CL_BRZ: begin
            w_pc_we = 1'b1; w_pc_sel = r_flags[1] ? PC_RS : PC_INC; w_state_next = ST_FETCH;
          end
          CL_BRN: begin
            w_pc_we = 1'b1; w_pc_sel = r_flags[0] ? PC_RS : PC_INC; w_state_next = ST_FETCH;
          end
          CL_ALU, CL_SVPC: w_state_next = ST_EXEC;
          CL_ST, CL_LD, CL_JM: w_state_next = ST_MEM;
`ifdef ILLEGAL_TRAP_EN
          CL_ILL: w_state_next = ST_HALT;
`endif
          default: begin
            w_pc_we = 1'b1; w_state_next = ST_FETCH;
          end
        endcase
      end
      ST_EXEC: begin
        w_alu_op    = w_cw.alu_op;
        w_alu_b_sel = w_cw.alu_b_sel;
        if (w_cw.sets_flags) w_flags_next = {alu_z, alu_n};
        w_state_next = ST_WB;
      end
      ST_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (w_cw.cls == CL_ST);
        if (mem_rdy) begin
          if (w_cw.cls == CL_LD) begin
            w_state_next = ST_WB;
          end else begin
            w_pc_we      = 1'b1;
            w_pc_sel     = (w_cw.cls == CL_JM) ? PC_MEM : PC_INC;
            w_state_next = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        w_reg_we     = 1'b1;
        w_wb_sel     = w_cw.wb_sel;
        w_pc_we      = 1'b1;
        w_state_next = ST_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      ST_HALT: w_state_next = ST_HALT;
`endif
      default: w_state_next = ST_FETCH;
    endcase
  end

  // Gate with rst_n so a reset landing mid-FETCH drops mem_req without waiting for a clock.
  assign mem_req   = rst_n & w_mem_req;
  assign mem_we    = rst_n & w_mem_we;
  assign ir_we     = rst_n & w_ir_we;
  assign pc_we     = rst_n & w_pc_we;
  assign reg_we    = rst_n & w_reg_we;
  assign alu_b_sel = rst_n & w_alu_b_sel;
  assign pc_sel    = {2{rst_n}} & w_pc_sel;
  assign wb_sel    = {2{rst_n}} & w_wb_sel;
  assign alu_op    = {2{rst_n}} & w_alu_op;
  assign state_o   = r_state;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = rst_n & (r_state == ST_HALT);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl; expected control words are hand-computed per cycle.
// Define ILLEGAL_TRAP_EN for both bench and RTL to exercise the HALT trap.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       alu_z = 1'b0, alu_n = 1'b0, mem_rdy = 1'b0;
  logic       mem_req, mem_we, ir_we, pc_we, reg_we, alu_b_sel, illegal;
  logic [1:0] pc_sel, wb_sel, alu_op;
  logic [2:0] state_o;
  logic [15:0] obs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_z(alu_z), .alu_n(alu_n),
    .mem_rdy(mem_rdy), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
    .alu_op(alu_op), .alu_b_sel(alu_b_sel), .state_o(state_o), .illegal(illegal)
  );

  assign obs = {mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, wb_sel, alu_op, alu_b_sel, state_o, illegal};

  // Same bit order as obs.
  function automatic logic [15:0] ev(input logic mreq, input logic mwe, input logic irwe,
                                     input logic pcwe, input logic [1:0] pcsel, input logic regwe,
                                     input logic [1:0] wbsel, input logic [1:0] aluop,
                                     input logic bsel, input logic [2:0] st, input logic ill);
    return {mreq, mwe, irwe, pcwe, pcsel, regwe, wbsel, aluop, bsel, st, ill};
  endfunction

  function automatic logic [15:0] fe(input logic rdy);
    return ev(1'b1, 1'b0, rdy, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0);
  endfunction

  function automatic logic [15:0] idle(input logic [2:0] st);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, st, 1'b0);
  endfunction

  function automatic logic [15:0] br(input logic [1:0] sel);
    return ev(1'b0, 1'b0, 1'b0, 1'b1, sel, 1'b0, 2'b00, 2'b00, 1'b0, 3'd1, 1'b0);
  endfunction

  function automatic logic [15:0] wb(input logic [1:0] sel);
    return ev(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, sel, 2'b00, 1'b0, 3'd4, 1'b0);
  endfunction

  function automatic logic [15:0] ex(input logic [1:0] op, input logic bsel);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, op, bsel, 3'd2, 1'b0);
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("vec %-10s ok  ctl=%h", tag, got);
    end
  endtask

  // Apply inputs on the falling edge, check after settling, advance one cycle.
  task automatic cyc(input string tag, input logic [3:0] op, input logic rdy,
                     input logic z, input logic n, input logic [15:0] exp);
    opcode = op; mem_rdy = rdy; alu_z = z; alu_n = n;
    #1;
    check_eq(tag, obs, exp);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("reset", obs, 16'h0000);
    rst_n = 1'b1;

    cyc("f_wait", 4'h0, 1'b0, 1'b0, 1'b0, fe(1'b0));
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid", obs, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // INC with zero-wait memory
    cyc("inc_f", 4'b0101, 1'b1, 1'b0, 1'b0, fe(1'b1));
    cyc("inc_d", 4'b0101, 1'b1, 1'b0, 1'b0, idle(3'd1));
    cyc("inc_e", 4'b0101, 1'b1, 1'b0, 1'b0, ex(2'b00, 1'b1));
    cyc("inc_w", 4'b0101, 1'b1, 1'b0, 1'b0, wb(2'b00));

    // LD with three wait cycles in MEM
    cyc("ld_f", 4'b1110, 1'b1, 1'b0, 1'b0, fe(1'b1));
    cyc("ld_d", 4'b1110, 1'b1, 1'b0, 1'b0, idle(3'd1));
    for (int i = 0; i < 3; i++)
      cyc("ld_mwait", 4'b1110, 1'b0, 1'b0, 1'b0, ev(1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'd3, 0));
    cyc("ld_mrdy", 4'b1110, 1'b1, 1'b0, 1'b0, ev(1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'd3, 0));
    cyc("ld_w", 4'b1110, 1'b1, 1'b0, 1'b0, wb(2'b01));

    // SUB sets Z=1, N=0
    cyc("sub_f", 4'b0111, 1'b1, 1'b0, 1'b0, fe(1'b1));
    cyc("sub_d", 4'b0111, 1'b1, 1'b0, 1'b0, idle(3'd1));
    cyc("sub_e", 4'b0111, 1'b1, 1'b1, 1'b0, ex(2'b01, 1'b0));
    cyc("sub_w", 4'b0111, 1'b1, 1'b0, 1'b0, wb(2'b00));

    // SVPC must not disturb the flags even with different ALU results
    cyc("svpc_f", 4'b1111, 1'b1, 1'b0, 1'b0, fe(1'b1));
    cyc("svpc_d", 4'b1111, 1'b1, 1'b0, 1'b0, idle(3'd1));
    cyc("svpc_e", 4'b1111, 1'b1, 1'b0, 1'b1, ex(2'b00, 1'b0));
    cyc("svpc_w", 4'b1111, 1'b1, 1'b0, 1'b0, wb(2'b10));

    cyc("brz1_f", 4'b1001, 1'b1, 1'b0, 1'b0, fe(1'b1));
    cyc("brz1_d", 4'b1001, 1'b1, 1'b0, 1'b0, br(2'b01));
    cyc("brn1_f", 4'b1011, 1'b1, 1'b0, 1'b0, fe(1'b1));
    cyc("brn1_d", 4'b1011, 1'b1, 1'b0, 1'b0, br(2'b00));

    // NEG sets Z=0, N=1
    cyc("neg_f", 4'b0110, 1'b1, 1'b0, 1'b0, fe(1'b1));
    cyc("neg_d", 4'b0110, 1'b1, 1'b0, 1'b0, idle(3'd1));
    cyc("neg_e", 4'b0110, 1'b1, 1'b0, 1'b1, ex(2'b10, 1'b0));
    cyc("neg_w", 4'b0110, 1'b1, 1'b0, 1'b0, wb(2'b00));

    cyc("brz0_f", 4'b1001, 1'b1, 1'b0, 1'b0, fe(1'b1));
    cyc("brz0_d", 4'b1001, 1'b1, 1'b0, 1'b0, br(2'b00));
    cyc("brn0_f", 4'b1011, 1'b1, 1'b0, 1'b0, fe(1'b1));
    cyc("brn0_d", 4'b1011, 1'b1, 1'b0, 1'b0, br(2'b01));

    cyc("j_f", 4'b1000, 1'b1, 1'b0, 1'b0, fe(1'b1));
    cyc("j_d", 4'b1000, 1'b1, 1'b0, 1'b0, br(2'b01));
    cyc("nop_f", 4'b0000, 1'b1, 1'b0, 1'b0, fe(1'b1));
    cyc("nop_d", 4'b0000, 1'b1, 1'b0, 1'b0, br(2'b00));

    // ST with one wait cycle, then JM
    cyc("st_f", 4'b0011, 1'b1, 1'b0, 1'b0, fe(1'b1));
    cyc("st_d", 4'b0011, 1'b1, 1'b0, 1'b0, idle(3'd1));
    cyc("st_mwait", 4'b0011, 1'b0, 1'b0, 1'b0, ev(1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'd3, 0));
    cyc("st_mrdy", 4'b0011, 1'b1, 1'b0, 1'b0, ev(1, 1, 0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 3'd3, 0));
    cyc("jm_f", 4'b1010, 1'b1, 1'b0, 1'b0, fe(1'b1));
    cyc("jm_d", 4'b1010, 1'b1, 1'b0, 1'b0, idle(3'd1));
    cyc("jm_m", 4'b1010, 1'b1, 1'b0, 1'b0, ev(1, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 3'd3, 0));

    // Unlisted opcode 1100
    cyc("ill_f", 4'b1100, 1'b1, 1'b0, 1'b0, fe(1'b1));
`ifdef ILLEGAL_TRAP_EN
    cyc("ill_d", 4'b1100, 1'b1, 1'b0, 1'b0, idle(3'd1));
    for (int i = 0; i < 10; i++)
      cyc("ill_halt", 4'b0000, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'd5, 1));
`else
    cyc("ill_d", 4'b1100, 1'b1, 1'b0, 1'b0, br(2'b00));
    cyc("ill_next", 4'b0000, 1'b1, 1'b0, 1'b0, fe(1'b1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
